cms_axis_packet_serializer: RTL and testbench
=============================================

# cms_axis_packet_serializer

Sits directly downstream of the continuous monitoring system's AXI-Stream master. Accepts full-width trace packets (instr, clk delta, pc, performance counters), buffers them in a small packet FIFO, and serializes each into narrow beats for the DMA/AXI-Stream FIFO. It propagates packet tlast onto the final beat only. It also exposes a buffer-level and sent-packet count for the Python control side.

## Interface
Parameters:
- IN_WIDTH, AXI_DATA_WIDTH: input packet width.
- OUT_WIDTH, 64: output beat width; legal values are 32, 64 and 128.
- FIFO_DEPTH, 4: packet FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- S_AXIS_tvalid  input  1  input packet valid.
- S_AXIS_tready  output  1  input packet accepted when high with tvalid.
- S_AXIS_tdata  input  IN_WIDTH  full trace packet.
- S_AXIS_tlast  input  1  packet closes a DMA transfer.
- M_AXIS_tvalid  output  1  output beat valid.
- M_AXIS_tready  input  1  downstream ready.
- M_AXIS_tdata  output  OUT_WIDTH  output beat.
- M_AXIS_tlast  output  1  last beat of a packet whose S_AXIS_tlast was set.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  packets currently stored, excluding the one being serialized.
- packets_sent  output  32  count of completed packets; wraps.

## Operation
- BEATS = ceil(IN_WIDTH/OUT_WIDTH).
- The packet is zero-extended at the MSB end to BEATS*OUT_WIDTH.
- Beat order is most-significant first: beat 0 is bits [BEATS*OUT_WIDTH-1 -: OUT_WIDTH]. This places instr in beat 0.
- Input side:
  - S_AXIS_tready = ~fifo_full. It is combinational from registered state only.
  - A push occurs on (S_AXIS_tvalid & S_AXIS_tready). Data and tlast are stored together.
  - There is no push while full, even if a pop occurs in the same cycle.
- FSM states are IDLE and SEND.
- IDLE:
  - If the FIFO is non-empty, pop the head into the shift register.
  - Set beat_cnt=0 and M_AXIS_tvalid=1, then go to SEND.
- SEND:
  - M_AXIS_tdata is the top OUT_WIDTH bits of the shift register.
  - On an output handshake with beat_cnt<BEATS-1: shift left by OUT_WIDTH and increment beat_cnt.
  - On an output handshake with beat_cnt==BEATS-1: increment packets_sent.
    - If the FIFO is non-empty, pop and load the next packet in the same edge and stay in SEND (no bubble).
    - Otherwise drop tvalid and go to IDLE.
- M_AXIS_tlast = (beat_cnt==BEATS-1) & stored_tlast. It is held stable with tdata.
- AXI rules:
  - Once M_AXIS_tvalid is high, tvalid, tdata and tlast hold until the handshake.
  - tvalid never depends on M_AXIS_tready.
- If BEATS==1, every beat is a last beat and the block degenerates to a packet FIFO.
- fifo_level:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - It reads FIFO_DEPTH exactly when full.

## Timing
- Reset values: S_AXIS_tready=1, M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0, fifo_level=0, packets_sent=0, FSM=IDLE, beat_cnt=0.
- Reset is asynchronous. Assertion mid-packet discards the partial packet and all FIFO contents immediately. There is no completion of the in-flight beat.
- Latency: a packet accepted at edge N is visible in the FIFO after N and loaded at N+1. M_AXIS_tvalid is high from N+1 (first beat 2 edges after acceptance, with FIFO empty and IDLE).
- Throughput: one packet per BEATS cycles under continuous M_AXIS_tready. The input can sustain one packet every BEATS cycles indefinitely.
- Stall: with M_AXIS_tready low, the FIFO fills. S_AXIS_tready falls in the cycle after the push that makes the FIFO full.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty is decided by an extra wrap bit.

## Structure
- Shared package gets:
  - CMS_OUT_AXI_DATA_WIDTH (64).
  - Function cms_beats_per_pkt(in_w, out_w) returning ceil(in_w/out_w).
  - typedef enum logic {SER_IDLE, SER_SEND} ser_state_t.
- Sub-module cms_packet_fifo (synchronous FIFO, width IN_WIDTH+1, async active-low reset, full/empty/level outputs).
- The top module holds the FSM, shift register, beat counter and packets_sent.

## Test plan
1. IN_WIDTH=160, OUT_WIDTH=64, M_AXIS_tready=1. Push tdata=0xAAAA_AAAA_1111_1111_2222_2222_3333_3333_4444_4444 with tlast=0.
   - Beats are 0x00000000_AAAAAAAA, 0x11111111_22222222, 0x33333333_44444444; tlast=0 throughout.
   - First beat arrives 2 edges after accept; packets_sent=1.
2. Same push with S_AXIS_tlast=1 -> M_AXIS_tlast=1 on beat 2 only.
3. M_AXIS_tready=0 and push 5 packets with FIFO_DEPTH=4.
   - 1 packet is loaded and 4 are stored, so fifo_level=4 and S_AXIS_tready=0.
   - 6th tvalid is not accepted.
   - Release ready: 15 beats in order, no duplicates or losses.
4. Continuous input with tready toggling 1,0,1,0.
   - tdata/tlast are stable across every low-ready cycle.
   - No bubble between the last beat of packet k and beat 0 of k+1 when the FIFO is non-empty.
5. Assert rst_n low during beat 1 with 2 packets queued.
   - Outputs go to reset values without waiting for a clock.
   - After release, no beat of the old packets appears; packets_sent=0.
6. Preload packets_sent near wrap via 2^32-1 completed packets (forced), then complete one more -> packets_sent wraps to 0.

Source files
------------

// File: rtl/cms_axis_packet_serializer_pkg.sv
// Shared types, widths and helpers for the CMS trace-packet serializer.
package cms_axis_packet_serializer_pkg;

    localparam int unsigned CMS_AXI_DATA_WIDTH     = 160;
    localparam int unsigned CMS_OUT_AXI_DATA_WIDTH = 64;

    typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;

    function automatic int unsigned cms_beats_per_pkt(input int unsigned in_w,
                                                      input int unsigned out_w);
        return (in_w + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/cms_axis_packet_serializer_if.sv
// AXI-Stream bundle (valid/ready/data/last) with master and slave views.
interface cms_axis_packet_serializer_if
    import cms_axis_packet_serializer_pkg::*;
#(
    parameter int unsigned DATA_W = CMS_OUT_AXI_DATA_WIDTH
) ();

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tlast, output tready);

endinterface

// File: rtl/cms_axis_packet_serializer_fifo.sv
// Packet FIFO: power-of-two depth, pointers carry an extra wrap bit for full/empty.
module cms_packet_fifo
    import cms_axis_packet_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 161,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle does not free a slot for a push while full.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cms_axis_packet_serializer.sv
// Buffers full-width trace packets and emits them MSB-first as narrow AXI-Stream beats.
module cms_axis_packet_serializer
    import cms_axis_packet_serializer_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = CMS_AXI_DATA_WIDTH,
    parameter int unsigned OUT_WIDTH  = CMS_OUT_AXI_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    cms_axis_packet_serializer_if.slave         S_AXIS,
    cms_axis_packet_serializer_if.master        M_AXIS,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic [31:0]                         packets_sent
);

    localparam int unsigned BEATS = cms_beats_per_pkt(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned SHW   = BEATS * OUT_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    ser_state_t       r_state;
    logic [SHW-1:0]   r_shift;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_last;
    logic             r_tvalid;
    logic [31:0]      r_packets_sent;

    logic             w_full;
    logic             w_empty;
    logic [IN_WIDTH:0] w_head;
    logic [SHW-1:0]   w_head_ext;
    logic             w_pop;
    logic             w_out_hs;
    logic             w_last_beat;

    cms_packet_fifo #(
        .WIDTH (IN_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (S_AXIS.tvalid),
        .i_data  ({S_AXIS.tlast, S_AXIS.tdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign S_AXIS.tready = ~w_full;

    always_comb begin
        w_head_ext = '0;
        w_head_ext[IN_WIDTH-1:0] = w_head[IN_WIDTH-1:0];
    end

    assign w_out_hs    = r_tvalid & M_AXIS.tready;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    // Load on idle, or back-to-back on the final beat's handshake so there is no bubble.
    assign w_pop = ~w_empty & ((r_state == SER_IDLE) | (w_out_hs & w_last_beat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= SER_IDLE;
            r_shift        <= '0;
            r_beat_cnt     <= '0;
            r_last         <= 1'b0;
            r_tvalid       <= 1'b0;
            r_packets_sent <= '0;
        end else begin
            case (r_state)
                SER_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_head_ext;
                        r_last     <= w_head[IN_WIDTH];
                        r_beat_cnt <= '0;
                        r_tvalid   <= 1'b1;
                        r_state    <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (w_out_hs) begin
                        if (!w_last_beat) begin
                            r_shift    <= r_shift << OUT_WIDTH;
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end else begin
                            r_packets_sent <= r_packets_sent + 32'd1;
                            r_beat_cnt     <= '0;
                            if (w_pop) begin
                                r_shift <= w_head_ext;
                                r_last  <= w_head[IN_WIDTH];
                            end else begin
                                r_tvalid <= 1'b0;
                                r_state  <= SER_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= SER_IDLE;
            endcase
        end
    end

    assign M_AXIS.tvalid = r_tvalid;
    assign M_AXIS.tdata  = r_shift[SHW-1 -: OUT_WIDTH];
    assign M_AXIS.tlast  = w_last_beat & r_last;
    assign packets_sent  = r_packets_sent;

endmodule

// File: tb/tb_cms_axis_packet_serializer.sv
// Self-checking bench: table vectors plus scoreboarded stall, toggle, reset and wrap sequences.
module tb_cms_axis_packet_serializer;

    localparam int unsigned IW = 160;
    localparam int unsigned OW = 64;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct {
        logic [IW-1:0] data;
        logic          last;
        logic [OW-1:0] b0;
        logic [OW-1:0] b1;
        logic [OW-1:0] b2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  fifo_level;
    logic [31:0] packets_sent;

    cms_axis_packet_serializer_if #(.DATA_W(IW)) s_if ();
    cms_axis_packet_serializer_if #(.DATA_W(OW)) m_if ();

    cms_axis_packet_serializer #(
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .S_AXIS       (s_if.slave),
        .M_AXIS       (m_if.master),
        .fifo_level   (fifo_level),
        .packets_sent (packets_sent)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    beat_t       sb[$];
    vec_t        vt[4];
    int unsigned sent_exp = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected beats for a packet: zero-extend to 192 bits, MSB beat first.
    task automatic expect_pkt(input logic [IW-1:0] data, input logic last);
        logic [191:0] ext;
        ext = {32'h0, data};
        for (int k = 0; k < 3; k++) begin
            sb.push_back({ext[191 - 64*k -: 64], last && (k == 2)});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push(input logic [IW-1:0] data, input logic last);
        int unsigned waited;
        waited = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = data;
        s_if.tlast  = last;
        while (!s_if.tready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check("push_timeout", waited < 200, 1);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int unsigned c;
        for (c = 0; c < 500; c++) begin
            if (sb.size() == 0 && !m_if.tvalid) break;
            @(posedge clk); #1;
        end
        check("drain_timeout", c < 500, 1);
    endtask

    function automatic logic [IW-1:0] rnd_pkt();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Output monitor: sampled on the falling edge, when inputs and outputs are settled.
    logic          hold_pending = 1'b0;
    logic [OW-1:0] hold_d;
    logic          hold_l;
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending) begin
                check("hold_stable", {m_if.tvalid, m_if.tdata, m_if.tlast}, {1'b1, hold_d, hold_l});
                hold_pending = 1'b0;
            end
            if (m_if.tvalid && !m_if.tready) begin
                hold_pending = 1'b1;
                hold_d = m_if.tdata;
                hold_l = m_if.tlast;
            end
            if (m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {m_if.tdata, m_if.tlast}, 0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat", {m_if.tdata, m_if.tlast}, e);
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        vt[0] = '{160'hAAAA_AAAA_1111_1111_2222_2222_3333_3333_4444_4444, 1'b0,
                  64'h00000000_AAAAAAAA, 64'h11111111_22222222, 64'h33333333_44444444};
        vt[1] = '{160'hAAAA_AAAA_1111_1111_2222_2222_3333_3333_4444_4444, 1'b1,
                  64'h00000000_AAAAAAAA, 64'h11111111_22222222, 64'h33333333_44444444};
        vt[2] = '{160'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF, 1'b1,
                  64'h00000000_01234567, 64'h89ABCDEF_FEDCBA98, 64'h76543210_DEADBEEF};
        vt[3] = '{{160{1'b1}}, 1'b0,
                  64'h00000000_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};

        rst_n       = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        #1;
        check("rst_s_tready", s_if.tready, 1);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_level", fifo_level, 0);
        check("rst_sent", packets_sent, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table vectors: single packets, free-running ready.
        for (int i = 0; i < 4; i++) begin
            push(vt[i].data, vt[i].last);
            sb.push_back({vt[i].b0, 1'b0});
            sb.push_back({vt[i].b1, 1'b0});
            sb.push_back({vt[i].b2, vt[i].last});
            check("lat_edge1_tvalid", m_if.tvalid, 0);
            @(posedge clk); #1;
            check("lat_edge2_tvalid", m_if.tvalid, 1);
            check("first_beat", m_if.tdata, vt[i].b0);
            drain();
            sent_exp++;
            check("sent_table", packets_sent, sent_exp);
        end

        // Stall: one packet loaded plus four stored, then the FIFO refuses a sixth.
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [IW-1:0] d;
            d = rnd_pkt();
            push(d, i[0]);
            expect_pkt(d, i[0]);
        end
        check("full_level", fifo_level, 4);
        check("full_tready", s_if.tready, 0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = rnd_pkt();
        repeat (3) begin @(posedge clk); #1; end
        check("no_accept_level", fifo_level, 4);
        check("no_accept_tready", s_if.tready, 0);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        drain();
        sent_exp += 5;
        check("sent_stall", packets_sent, sent_exp);

        // No bubble between packets when the FIFO is non-empty.
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [IW-1:0] d;
            d = rnd_pkt();
            push(d, 1'b1);
            expect_pkt(d, 1'b1);
        end
        m_if.tready = 1'b1;
        begin
            int unsigned bubbles;
            bubbles = 0;
            repeat (9) begin
                @(negedge clk);
                if (!m_if.tvalid) bubbles++;
            end
            check("no_bubble", bubbles, 0);
        end
        drain();
        sent_exp += 3;
        check("sent_bubble", packets_sent, sent_exp);

        // Continuous input while downstream ready toggles every cycle.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [IW-1:0] d;
                    logic          l;
                    d = rnd_pkt();
                    l = $urandom_range(0, 1) != 0;
                    push(d, l);
                    expect_pkt(d, l);
                end
            end
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    m_if.tready = ~m_if.tready;
                end
            end
        join
        m_if.tready = 1'b1;
        drain();
        sent_exp += 6;
        check("sent_toggle", packets_sent, sent_exp);

        // Asynchronous reset during beat 1 with two packets queued.
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [IW-1:0] d;
            d = rnd_pkt();
            push(d, 1'b1);
            expect_pkt(d, 1'b1);
        end
        check("pre_rst_level", fifo_level, 2);
        m_if.tready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", m_if.tvalid, 0);
        check("arst_m_tdata", m_if.tdata, 0);
        check("arst_m_tlast", m_if.tlast, 0);
        check("arst_level", fifo_level, 0);
        check("arst_s_tready", s_if.tready, 1);
        check("arst_sent", packets_sent, 0);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        begin
            int unsigned stray;
            stray = 0;
            repeat (12) begin
                @(negedge clk);
                if (m_if.tvalid) stray++;
            end
            check("no_stale_beats", stray, 0);
        end
        check("post_rst_sent", packets_sent, 0);

        // packets_sent wrap from all-ones.
        @(posedge clk); #1;
        force dut.r_packets_sent = 32'hFFFF_FFFF;
        #1 release dut.r_packets_sent;
        #1 check("preload_sent", packets_sent, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        begin
            logic [IW-1:0] d;
            d = rnd_pkt();
            push(d, 1'b0);
            expect_pkt(d, 1'b0);
        end
        drain();
        check("sent_wrap", packets_sent, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
